// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_CORR_THRESH = 4'd5;
  localparam bcd_digit_t BCD_CORR_ADD    = 4'd3;

endpackage

// File: rtl/bcd_add3.sv
// Per-digit double-dabble correction: digits of 5 or more get +3 before the shift.
module bcd_add3
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  output bcd_digit_t corrected
);

  always_comb begin
    corrected = digit;
    if (digit >= BCD_CORR_THRESH) corrected = digit + BCD_CORR_ADD;
  end

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Sequential double-dabble converter: one shift-and-correct step per clock,
// framed by a start/done handshake.
module binary_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned BW = 4 * DIGITS;

  state_t             state, state_next;
  logic [WIDTH-1:0]   bin_sr;
  logic [BW-1:0]      bcd_work;
  logic [BW-1:0]      bcd_corr;
  logic               ovf_acc;
  logic [CW-1:0]      cnt;
  logic [BW+WIDTH-1:0] shift_next;
  logic               shift_out;
  logic               accept;
  logic               last_step;

  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    bcd_add3 u_add3 (
      .digit     (bcd_work[4*g +: 4]),
      .corrected (bcd_corr[4*g +: 4])
    );
  end

  // The top bit of the corrected top digit leaves the register; a 1 here is a carry worth 10^DIGITS.
  assign shift_out  = bcd_corr[BW-1];
  assign shift_next = {bcd_corr[BW-2:0], bin_sr, 1'b0};

  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last_step = (state == SHIFT) && (cnt == CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? SHIFT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_sr   <= '0;
      bcd_work <= '0;
      ovf_acc  <= 1'b0;
      cnt      <= '0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      bin_sr   <= bin_in;
      bcd_work <= '0;
      ovf_acc  <= 1'b0;
      cnt      <= CW'(WIDTH);
    end else if (state == SHIFT) begin
      {bcd_work, bin_sr} <= shift_next;
      ovf_acc            <= ovf_acc | shift_out;
      cnt                <= cnt - CW'(1);
      if (last_step) begin
        bcd_out  <= shift_next[BW+WIDTH-1 -: BW];
        overflow <= ovf_acc | shift_out;
      end
    end
  end

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Directed self-checking bench for binary_to_bcd_seq (5-digit default and a 4-digit instance).
module tb_binary_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start4;
  logic [15:0] bin_in, bin_in4;
  logic        busy, done, overflow;
  logic        busy4, done4, overflow4;
  logic [19:0] bcd_out;
  logic [15:0] bcd_out4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  binary_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow)
  );

  binary_to_bcd_seq #(.WIDTH(16), .DIGITS(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .bin_in(bin_in4),
    .busy(busy4), .done(done4), .bcd_out(bcd_out4), .overflow(overflow4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned t;
    r = '0;
    t = v;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Pulse start for one edge, then count negedges until done (bounded).
  task automatic run5(input logic [15:0] v, output int lat);
    @(negedge clk);
    bin_in = v;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 16'hFFFF;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run4(input logic [15:0] v, output int lat);
    @(negedge clk);
    bin_in4 = v;
    start4  = 1'b1;
    @(negedge clk);
    start4  = 1'b0;
    lat = 1;
    while (!done4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int pulses;
    logic [15:0] spot [4];
    logic [19:0] spot_exp [4];

    reset = 1'b1; start = 1'b0; start4 = 1'b0; bin_in = '0; bin_in4 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_bcd", 32'(bcd_out), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    reset = 1'b0;

    run5(16'd0, lat);
    chk("zero_lat", 32'(lat), 32'd17);
    chk("zero_bcd", 32'(bcd_out), 32'h00000);
    chk("zero_ovf", 32'(overflow), 32'h0);
    chk("done_busy_low", 32'(busy), 32'h0);
    @(negedge clk);
    chk("done_single", 32'(done), 32'h0);
    chk("bcd_hold", 32'(bcd_out), 32'h00000);

    run5(16'd65535, lat);
    chk("max_lat", 32'(lat), 32'd17);
    chk("max_bcd", 32'(bcd_out), 32'h65535);
    chk("max_ovf", 32'(overflow), 32'h0);

    spot[0] = 16'd1234; spot_exp[0] = 20'h01234;
    spot[1] = 16'd9;    spot_exp[1] = 20'h00009;
    spot[2] = 16'd10;   spot_exp[2] = 20'h00010;
    spot[3] = 16'd9999; spot_exp[3] = 20'h09999;
    for (int i = 0; i < 4; i++) begin
      run5(spot[i], lat);
      chk($sformatf("spot_%0d", spot[i]), 32'(bcd_out), 32'(spot_exp[i]));
    end

    for (int v = 0; v < 120; v++) begin
      run5(16'(v), lat);
      chk($sformatf("sweep_%0d", v), 32'(bcd_out), 32'(ref_bcd(v)));
    end
    for (int v = 9990; v < 10010; v++) begin
      run5(16'(v), lat);
      chk($sformatf("sweep_%0d", v), 32'(bcd_out), 32'(ref_bcd(v)));
    end

    run4(16'd12345, lat);
    chk("d4_12345_bcd", 32'(bcd_out4), 32'h2345);
    chk("d4_12345_ovf", 32'(overflow4), 32'h1);
    run4(16'd9999, lat);
    chk("d4_9999_bcd", 32'(bcd_out4), 32'h9999);
    chk("d4_9999_ovf", 32'(overflow4), 32'h0);
    run4(16'd10000, lat);
    chk("d4_10000_bcd", 32'(bcd_out4), 32'h0000);
    chk("d4_10000_ovf", 32'(overflow4), 32'h1);

    // Second start mid-conversion must be ignored.
    @(negedge clk);
    bin_in = 16'd1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; pulses = 0;
    while (lat < 25) begin
      if (lat == 5) begin bin_in = 16'd42; start = 1'b1; end
      if (lat == 6) start = 1'b0;
      if (done) begin
        pulses++;
        chk("ign_lat", 32'(lat), 32'd17);
        chk("ign_bcd", 32'(bcd_out), 32'h01234);
      end
      @(negedge clk);
      lat++;
    end
    chk("ign_pulses", 32'(pulses), 32'd1);

    // Back-to-back with start held: done every 17 cycles.
    @(negedge clk);
    bin_in = 16'd321; start = 1'b1;
    lat = 0; pulses = 0;
    while (pulses < 2 && lat < 60) begin
      @(negedge clk);
      lat++;
      if (done) begin
        pulses++;
        chk($sformatf("b2b_lat_%0d", pulses), 32'(lat), 32'(17 * pulses));
        chk($sformatf("b2b_bcd_%0d", pulses), 32'(bcd_out), 32'h00321);
      end
    end
    start = 1'b0;
    chk("b2b_pulses", 32'(pulses), 32'd2);
    repeat (20) @(negedge clk);

    // Reset mid-conversion aborts with no done pulse.
    run5(16'd777, lat);
    chk("pre_rst_bcd", 32'(bcd_out), 32'h00777);
    @(negedge clk);
    bin_in = 16'd4321; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_bcd", 32'(bcd_out), 32'h0);
    chk("abort_ovf", 32'(overflow), 32'h0);
    @(negedge clk);
    start = 1'b1; bin_in = 16'd77;
    @(negedge clk);
    chk("start_in_rst", 32'(busy), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("start_after_rst", 32'(busy), 32'h1);
    lat = 1; pulses = 0;
    while (lat < 30) begin
      if (done) begin
        pulses++;
        chk("post_rst_lat", 32'(lat), 32'd17);
        chk("post_rst_bcd", 32'(bcd_out), 32'h00077);
      end
      @(negedge clk);
      lat++;
    end
    chk("post_rst_pulses", 32'(pulses), 32'd1);

    run5(16'd4321, lat);
    chk("fresh_lat", 32'(lat), 32'd17);
    chk("fresh_bcd", 32'(bcd_out), 32'h04321);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
